// File: rtl/layer_mixer_pkg.sv
// Shared constants for the layer mixer.
// Holds the default colour width, the default flash half-period in frames,
// the frame counter width and the colour-code constants.
package layer_mixer_pkg;

  localparam int COLOR_W_DEF      = 2;
  localparam int FLASH_FRAMES_DEF = 16;
  localparam int FRAME_CNT_W      = 8;

  // Colour codes; BLACK is the only code with a fixed meaning in the mixer.
  localparam int BLACK = 0;

endpackage

// File: rtl/flash_timer.sv
// Flash timer.
// Detects VSync rising edges against a registered copy of VSync, counts frames
// and toggles the flash phase once every FLASH_FRAMES frames.
// Ports:
//   clk_i     pixel clock
//   rst_i     asynchronous active-high reset
//   vsync_i   active-high vertical sync
//   phase_o   current flash phase
module flash_timer
  import layer_mixer_pkg::*;
#(
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  output logic phase_o
);

  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(FLASH_FRAMES - 1);

  logic                   vsync_q;
  logic                   phase_q, phase_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   vsync_rise;

  // The edge register resets high so a VSync already high at reset release
  // is not mistaken for a new frame.
  assign vsync_rise = vsync_i & ~vsync_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (vsync_rise) begin
      if (cnt_q == LAST_FRAME) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q <= 1'b1;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/layer_mixer.sv
// Layer mixer.
// Selects the colour of the highest-priority (lowest-index) visible layer,
// applies flash suppression, window inversion and blanking, and produces a
// composite sync. Every output has a latency of two Clk6 cycles.
// Ports:
//   Clk6        pixel clock
//   Reset       asynchronous active-high reset
//   HSync/VSync active-high sync inputs
//   HBlank_n/VBlank_n active-low blanking inputs
//   LayerVid    per-layer pixel-on
//   LayerColor  per-layer colour, layer i at [i*COLOR_W +: COLOR_W]
//   FlashMask   layers hidden while FlashPhase is 1
//   Window      invert-window enable
//   CSync       composite sync, active-low
//   VideoOut    mixed colour, 0 = black
//   BlankOut    composite blank, active-high
//   FlashPhase  current flash phase
module layer_mixer
  import layer_mixer_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = COLOR_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic                          Clk6,
  input  logic                          Reset,
  input  logic                          HSync,
  input  logic                          VSync,
  input  logic                          HBlank_n,
  input  logic                          VBlank_n,
  input  logic [NUM_LAYERS-1:0]         LayerVid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] LayerColor,
  input  logic [NUM_LAYERS-1:0]         FlashMask,
  input  logic                          Window,
  output logic                          CSync,
  output logic [COLOR_W-1:0]            VideoOut,
  output logic                          BlankOut,
  output logic                          FlashPhase
);

  logic               flash_phase;

  logic [COLOR_W-1:0] s1_color_q, s1_color_d;
  logic               s1_window_q, s1_window_d;
  logic               s1_blank_q, s1_blank_d;
  logic               s1_sync_q, s1_sync_d;

  logic [COLOR_W-1:0] video_q, video_d;
  logic               blank_q;
  logic               csync_q;

  flash_timer #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash_timer (
    .clk_i   (Clk6),
    .rst_i   (Reset),
    .vsync_i (VSync),
    .phase_o (flash_phase)
  );

  always_comb begin
    s1_color_d = COLOR_W'(BLACK);
    // Walk from lowest to highest priority so the lowest eligible index wins.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (LayerVid[i] && !(FlashMask[i] && flash_phase)) begin
        s1_color_d = LayerColor[i*COLOR_W +: COLOR_W];
      end
    end
    s1_window_d = Window;
    s1_blank_d  = ~(HBlank_n & VBlank_n);
    s1_sync_d   = ~(HSync | VSync);

    // Inversion also applies to background, so black becomes all-ones.
    video_d = s1_color_q ^ {COLOR_W{s1_window_q & flash_phase}};
    if (s1_blank_q) begin
      video_d = COLOR_W'(BLACK);
    end
  end

  always_ff @(posedge Clk6 or posedge Reset) begin
    if (Reset) begin
      s1_color_q  <= COLOR_W'(BLACK);
      s1_window_q <= 1'b0;
      s1_blank_q  <= 1'b1;
      s1_sync_q   <= 1'b1;
      video_q     <= COLOR_W'(BLACK);
      blank_q     <= 1'b1;
      csync_q     <= 1'b1;
    end else begin
      s1_color_q  <= s1_color_d;
      s1_window_q <= s1_window_d;
      s1_blank_q  <= s1_blank_d;
      s1_sync_q   <= s1_sync_d;
      video_q     <= video_d;
      blank_q     <= s1_blank_q;
      csync_q     <= s1_sync_q;
    end
  end

  assign VideoOut   = video_q;
  assign BlankOut   = blank_q;
  assign CSync      = csync_q;
  assign FlashPhase = flash_phase;

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of video layers (1..8); layer 0 is highest priority.
REQ-002 SHALL have parameter COLOR_W, default 2, width of each layer colour code and of VideoOut.
REQ-003 SHALL have parameter FLASH_FRAMES, default 16, frames per flash half-period (2..255).
REQ-004 Clk6  input  1  pixel clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 HSync, VSync  input  1 each  active-high sync.
REQ-007 HBlank_n, VBlank_n  input  1 each  active-low blanking.
REQ-008 LayerVid  input  NUM_LAYERS  per-layer pixel-on.
REQ-009 LayerColor  input  NUM_LAYERS*COLOR_W  per-layer colour; layer i at bits [i*COLOR_W +: COLOR_W].
REQ-010 FlashMask  input  NUM_LAYERS  layer i suppressed while FlashPhase=1.
REQ-011 Window  input  1  invert-window; output colour complemented while Window=1 and FlashPhase=1.
REQ-012 CSync  output  1  composite sync, active-low.
REQ-013 VideoOut  output  COLOR_W  mixed colour; 0 = black.
REQ-014 BlankOut  output  1  composite blank, active-high.
REQ-015 FlashPhase  output  1  current flash phase.

Function
REQ-016 Stage 1 (registered): per layer, eligible = LayerVid[i] & ~(FlashMask[i] & FlashPhase); SHALL register colour of lowest-index eligible layer, else 0; SHALL register Window, CompBlank = ~(HBlank_n & VBlank_n), CompSync = ~(HSync | VSync).
REQ-017 Stage 2 (registered): colour = stage-1 colour XOR all-ones when stage-1 Window & FlashPhase; VideoOut SHALL be 0 when stage-1 CompBlank=1, else that colour.
REQ-018 Window inversion SHALL apply to background (colour 0) too, producing all-ones inside the window during blank-free pixels.
REQ-019 CSync and BlankOut SHALL be delayed through both stages so all outputs share latency of exactly 2 Clk6 cycles from inputs.
REQ-020 Frame counter (8 bits) SHALL increment on each VSync rising edge, detected against a registered copy of VSync.
REQ-021 When counter reaches FLASH_FRAMES-1 and a VSync rising edge occurs, counter SHALL return to 0 and FlashPhase SHALL toggle in the same cycle.
REQ-022 FlashPhase changes SHALL only take effect in Stage 1/2 from the cycle after the toggle; no mid-pixel glitches on outputs.
REQ-023 VSync held high for many cycles SHALL count as one edge; VSync high during reset release SHALL not count an edge.
REQ-024 Simultaneous LayerVid on all layers SHALL yield layer 0 colour unless layer 0 is flash-suppressed, in which case next eligible lowest index.
REQ-025 NUM_LAYERS=1 SHALL degenerate to pass-through of layer 0 with flash, window and blank.

Reset
REQ-026 During Reset: VideoOut=0, BlankOut=1, CSync=1, FlashPhase=0, frame counter=0, VSync edge register=1, all pipeline registers cleared to blank/no-sync state.
REQ-027 Reset asserted mid-frame SHALL force REQ-026 values asynchronously; after deassertion, first valid output SHALL appear on the 2nd rising edge.

Structure
REQ-028 Shared package SHALL hold COLOR_W default, FLASH_FRAMES default and the colour-code constants (BLACK=0).
REQ-029 One sub-module, flash_timer (VSync edge detect, frame counter, FlashPhase), SHALL be instantiated; priority select and pipeline live in layer_mixer.

Verification
REQ-030 LayerVid=4'b0110, colours L1=2, L2=3, blanks inactive -> VideoOut=2 exactly two cycles later.
REQ-031 FlashMask=4'b0010, FlashPhase=1, same stimulus as REQ-030 -> VideoOut=3; with FlashPhase=0 -> 2.
REQ-032 FLASH_FRAMES=4, 10 VSync pulses from reset -> FlashPhase toggles after pulses 4 and 8; final value 0, counter=2.
REQ-033 Window=1, FlashPhase=1, LayerVid=0 -> VideoOut=3 (COLOR_W=2); HBlank_n=0 same cycle -> VideoOut=0, BlankOut=1.
REQ-034 HSync=1 pulse of 5 cycles -> CSync low for exactly 5 cycles, starting 2 cycles after HSync rises, aligned with BlankOut.
REQ-035 Reset asserted mid-line with VideoOut=3 -> outputs take REQ-026 values immediately; after release, VSync held high produces no FlashPhase/counter change.
